// File: rtl/sr_drv_pkg.sv
// sr_drv_pkg
//   Definitions shared by the SR latch driver and its timer:
//   FSM state encoding, operation codes and default pulse/gap lengths.
package sr_drv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2,
        ST_CHECK = 2'd3
    } state_t;

    localparam logic OP_SET = 1'b1;
    localparam logic OP_RST = 1'b0;

    localparam int PULSE_W_DEF = 2;
    localparam int GAP_W_DEF   = 2;

endpackage

// File: rtl/sr_pulse_timer.sv
// sr_pulse_timer
//   Loadable down-counter that times both the pulse and the gap phase.
//   Counting stops at zero, so it never wraps.
// Ports
//   clk       in   clock, rising edge
//   rst       in   synchronous reset, active-high (count -> 0)
//   load      in   load load_val on this edge (takes priority over counting)
//   load_val  in   CNT_W-bit reload value
//   zero      out  count is zero
module sr_pulse_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sr_latch_driver.sv
// sr_latch_driver
//   Turns set/reset requests from a valid/ready port into timed pulses on
//   the s/r inputs of an SR NAND latch. s and r are never high together and
//   both return to hold (0/0) for a gap before the operation completes.
//   Optional feature macro: SR_READBACK_EN adds a CHECK state that samples
//   Q/Q_bar after the gap and flags a mismatch on err.
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous reset, active-high
//   req_valid  in   request present
//   req_set    in   1 = set (pulse s), 0 = reset (pulse r)
//   req_ready  out  idle, request accepted on the next edge if valid
//   s, r       out  registered latch drives
//   Q, Q_bar   in   latch readback (used only with SR_READBACK_EN)
//   done       out  one-cycle completion pulse, coincides with req_ready=1
//   err        out  one-cycle readback mismatch, alongside done
module sr_latch_driver
    import sr_drv_pkg::*;
#(
    parameter int PULSE_W = PULSE_W_DEF,
    parameter int GAP_W   = GAP_W_DEF,
    parameter int CNT_W   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req_valid,
    input  logic req_set,
    output logic req_ready,
    output logic s,
    output logic r,
    input  logic Q,
    input  logic Q_bar,
    output logic done,
    output logic err
);

    state_t           state, state_nxt;
    logic             op, op_nxt;
    logic             s_nxt, r_nxt, done_nxt, err_nxt;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic             zero;
    logic             accept;

    sr_pulse_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .zero     (zero)
    );

    assign req_ready = (state == ST_IDLE);
    assign accept    = req_valid & req_ready;

`ifndef SR_READBACK_EN
    // Readback pins have no function in this build.
    logic unused_readback;
    assign unused_readback = Q ^ Q_bar;
`endif

    // s/r are registered from the next state, so the pulse begins in the
    // cycle right after the accepting edge and ends exactly PULSE_W cycles later.
    always_comb begin
        state_nxt = state;
        op_nxt    = op;
        load      = 1'b0;
        load_val  = '0;
        s_nxt     = 1'b0;
        r_nxt     = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_PULSE;
                    op_nxt    = req_set;
                    load      = 1'b1;
                    load_val  = CNT_W'(PULSE_W - 1);
                    s_nxt     = (req_set == OP_SET);
                    r_nxt     = (req_set == OP_RST);
                end
            end
            ST_PULSE: begin
                if (zero) begin
                    state_nxt = ST_GAP;
                    load      = 1'b1;
                    load_val  = CNT_W'(GAP_W - 1);
                end else begin
                    s_nxt = (op == OP_SET);
                    r_nxt = (op == OP_RST);
                end
            end
            ST_GAP: begin
                if (zero) begin
`ifdef SR_READBACK_EN
                    state_nxt = ST_CHECK;
`else
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
`endif
                end
            end
`ifdef SR_READBACK_EN
            ST_CHECK: begin
                state_nxt = ST_IDLE;
                done_nxt  = 1'b1;
                // Q must match the operation and the two rails must differ.
                err_nxt   = (Q != op) || (Q == Q_bar);
            end
`endif
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            op    <= OP_RST;
            s     <= 1'b0;
            r     <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            op    <= op_nxt;
            s     <= s_nxt;
            r     <= r_nxt;
            done  <= done_nxt;
            err   <= err_nxt;
        end
    end

endmodule

// File: tb/tb_sr_latch_driver.sv
// tb_sr_latch_driver
//   Two driver instances (PULSE_W/GAP_W = 2/2 and 1/1), each wired to a
//   behavioural SR latch model. Requests push their expected outcome into a
//   scoreboard queue; a negedge monitor pops and checks on every done.
module tb_sr_latch_driver;

`ifdef SR_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif
    localparam int PW0 = 2, GW0 = 2, PW1 = 1, GW1 = 1;
    // Edges from the accepting edge to the edge that raises done.
    localparam int LAT0 = PW0 + GW0 + RB;
    localparam int LAT1 = PW1 + GW1 + RB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [1:0] req_valid, req_set, req_ready, s, r, done, err, qb, fault;
    logic [1:0] q = 2'b00;

    sr_latch_driver #(.PULSE_W(PW0), .GAP_W(GW0), .CNT_W(4)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_set(req_set[0]),
        .req_ready(req_ready[0]), .s(s[0]), .r(r[0]), .Q(q[0]), .Q_bar(qb[0]),
        .done(done[0]), .err(err[0]));

    sr_latch_driver #(.PULSE_W(PW1), .GAP_W(GW1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_set(req_set[1]),
        .req_ready(req_ready[1]), .s(s[1]), .r(r[1]), .Q(q[1]), .Q_bar(qb[1]),
        .done(done[1]), .err(err[1]));

    // Latch model: s sets, r clears; fault forces Q_bar high (Q = Q_bar = 1 after a set).
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (s[i])      q[i] <= 1'b1;
            else if (r[i]) q[i] <= 1'b0;
        end
    end
    assign qb = fault | ~q;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lat_of(input int i);
        return (i == 0) ? LAT0 : LAT1;
    endfunction

    function automatic int pw_of(input int i);
        return (i == 0) ? PW0 : PW1;
    endfunction

    typedef struct {
        int   inst;
        logic set;
        logic err;
        logic qb;
    } exp_t;
    exp_t exp_q[$];

    // ---------------- monitor ----------------
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   acc_edge[2];
    logic busy[2];
    int   pcnt[2];
    logic pol_bad[2];
    logic cur_set[2];
    exp_t e;

    initial begin
        for (int i = 0; i < 2; i++) begin
            busy[i] = 1'b0; pcnt[i] = 0; pol_bad[i] = 1'b0; acc_edge[i] = 0; cur_set[i] = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (cyc >= 1) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("mutex%0d", i), {31'd0, s[i] & r[i]}, 32'd0);
                chk($sformatf("ready%0d", i), {31'd0, req_ready[i]},
                    {31'd0, !(busy[i] && cyc >= acc_edge[i] && cyc < acc_edge[i] + lat_of(i))});
                if (done[i]) begin
                    if (exp_q.size() == 0) begin
                        chk($sformatf("unexpected_done%0d", i), 32'd1, 32'd0);
                    end else if (exp_q[0].inst != i) begin
                        chk($sformatf("unexpected_done%0d", i), 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("latency%0d", i), cyc - acc_edge[i], lat_of(i));
                        chk($sformatf("err%0d", i), {31'd0, err[i]}, {31'd0, e.err});
                        chk($sformatf("Q%0d", i), {31'd0, q[i]}, {31'd0, e.set});
                        chk($sformatf("Q_bar%0d", i), {31'd0, qb[i]}, {31'd0, e.qb});
                        chk($sformatf("pulse_w%0d", i), pcnt[i], pw_of(i));
                        chk($sformatf("polarity%0d", i), {31'd0, pol_bad[i]}, 32'd0);
                    end
                    busy[i] = 1'b0;
                end else begin
                    chk($sformatf("err_idle%0d", i), {31'd0, err[i]}, 32'd0);
                end
                if (s[i] | r[i]) begin
                    pcnt[i]++;
                    if (s[i] != cur_set[i]) pol_bad[i] = 1'b1;
                end
                if (rst) begin
                    busy[i] = 1'b0; pcnt[i] = 0; pol_bad[i] = 1'b0;
                end else if (req_valid[i] && req_ready[i]) begin
                    busy[i] = 1'b1; acc_edge[i] = cyc + 1; pcnt[i] = 0;
                    pol_bad[i] = 1'b0; cur_set[i] = req_set[i];
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input int i, input logic set, input logic exp_err, input logic exp_qb);
        exp_t n;
        int   k;
        n.inst = i; n.set = set; n.err = exp_err; n.qb = exp_qb;
        exp_q.push_back(n);
        req_valid[i] = 1'b1;
        req_set[i]   = set;
        k = 0;
        while (req_ready[i] !== 1'b1 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (k == 100) chk($sformatf("accept_timeout%0d", i), 32'd1, 32'd0);
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_done(input int i);
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (done[i] === 1'b1) return;
        end
        chk($sformatf("done_timeout%0d", i), 32'd1, 32'd0);
    endtask

    initial begin
        rst = 1'b1; req_valid = 2'b00; req_set = 2'b00; fault = 2'b00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // 1: reset state
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_s%0d", i), {31'd0, s[i]}, 32'd0);
            chk($sformatf("rst_r%0d", i), {31'd0, r[i]}, 32'd0);
            chk($sformatf("rst_ready%0d", i), {31'd0, req_ready[i]}, 32'd1);
            chk($sformatf("rst_done%0d", i), {31'd0, done[i]}, 32'd0);
        end
        repeat (2) @(posedge clk);
        #1;

        // 2: set op, pulse shape checked directly too
        issue(0, 1'b1, 1'b0, 1'b0);
        chk("set_s_T1", {31'd0, s[0]}, 32'd1);
        @(posedge clk); #1;
        chk("set_s_T2", {31'd0, s[0]}, 32'd1);
        @(posedge clk); #1;
        chk("set_s_T3", {31'd0, s[0]}, 32'd0);
        wait_done(0);

        // 3: back-to-back set then reset, reset issued in the done cycle
        issue(0, 1'b1, 1'b0, 1'b0);
        wait_done(0);
        issue(0, 1'b0, 1'b0, 1'b1);
        chk("b2b_r", {31'd0, r[0]}, 32'd1);
        wait_done(0);
        chk("b2b_Q", {31'd0, q[0]}, 32'd0);

        // 4: reset during PULSE aborts the op without done
        issue(0, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        void'(exp_q.pop_back());
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_s", {31'd0, s[0]}, 32'd0);
        chk("abort_ready", {31'd0, req_ready[0]}, 32'd1);
        repeat (8) @(posedge clk);
        #1;
        issue(0, 1'b0, 1'b0, 1'b1);
        wait_done(0);

`ifdef SR_READBACK_EN
        // 5: stuck latch (Q = Q_bar = 1) on a set op flags err
        fault[0] = 1'b1;
        issue(0, 1'b1, 1'b1, 1'b1);
        wait_done(0);
        fault[0] = 1'b0;
        @(posedge clk); #1;
`endif

        // 6: minimum pulse and gap
        issue(1, 1'b1, 1'b0, 1'b0);
        chk("min_s_T1", {31'd0, s[1]}, 32'd1);
        @(posedge clk); #1;
        chk("min_s_T2", {31'd0, s[1]}, 32'd0);
        wait_done(1);
        issue(1, 1'b0, 1'b0, 1'b1);
        wait_done(1);

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
